// File: rtl/timer_digit_loader_pkg.sv
// Shared definitions for the keypad-to-timer digit loader: BCD widths, FSM states, key validation.
package timer_digit_loader_pkg;

  localparam int          BCD_W          = 4;
  localparam logic [3:0]  BCD_MAX        = 4'd9;
  localparam logic [3:0]  KEY_CODE_LIMIT = 4'd10;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  function automatic logic is_bcd(input logic [3:0] code);
    return (code < KEY_CODE_LIMIT) && (code <= BCD_MAX);
  endfunction

endpackage

// File: rtl/timer_digit_loader_if.sv
// Keypad/timer-side signal bundle of the digit loader; master drives keys, slave is the loader.
interface timer_digit_loader_if #(
  parameter int NUM_DIGITS = 4
);
  import timer_digit_loader_pkg::*;

  logic                        key_valid;
  bcd_t                        key_code;
  logic                        key_clear;
  logic                        start;
  logic                        timer_running;
  logic [NUM_DIGITS-1:0][3:0]  digits_out;
  logic                        loadn;
  logic [2:0]                  digit_count;
  logic                        load_done;

  modport master (
    output key_valid, key_code, key_clear, start, timer_running,
    input  digits_out, loadn, digit_count, load_done
  );

  modport slave (
    input  key_valid, key_code, key_clear, start, timer_running,
    output digits_out, loadn, digit_count, load_done
  );

endinterface

// File: rtl/timer_digit_loader_bcd_shift_buffer.sv
// NUM_DIGITS x BCD shift-in register; new digit enters slot 0, older digits move up one slot.
module bcd_shift_buffer
  import timer_digit_loader_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                       clock,
  input  logic                       clearn,
  input  logic                       clr,
  input  logic                       shift,
  input  bcd_t                       din,
  output logic [NUM_DIGITS-1:0][3:0] digits,
  output logic [2:0]                 count,
  output logic                       full
);

  localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

  always_ff @(posedge clock) begin
    if (!clearn || clr) begin
      digits <= '0;
      count  <= '0;
    end else if (shift) begin
      digits <= {digits[NUM_DIGITS-2:0], din};
      count  <= count + 3'd1;
    end
  end

  // Shifting is refused by the caller when full, so the top digit is never lost.
  assign full = (count == FULL_CNT);

endmodule

// File: rtl/timer_digit_loader.sv
// Collects keypad digits into an MM:SS buffer and parallel-loads the stopped BCD counter chain.
module timer_digit_loader
  import timer_digit_loader_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  clearn,
  timer_digit_loader_if.slave   bus
);

  state_e     state;
  logic       key_valid_q;
  logic [3:0] load_cnt;
  logic       loadn_r;
  logic       load_done_r;
  logic [2:0] count;
  logic       full;

  logic key_rise, entry_st, buf_clr, start_ok, shift;

  assign key_rise = bus.key_valid & ~key_valid_q;
  assign entry_st = (state == ST_IDLE) || (state == ST_ENTRY);

  // Priority: key_clear over start over key entry; RELEASE empties the buffer after a load.
  assign buf_clr  = (entry_st & bus.key_clear) | (state == ST_RELEASE);
  assign start_ok = entry_st & ~bus.key_clear & bus.start & (count != 3'd0) & ~bus.timer_running;
  assign shift    = entry_st & ~bus.key_clear & ~start_ok & key_rise & is_bcd(bus.key_code)
                  & ~bus.timer_running & ~full;

  bcd_shift_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_buf (
    .clock  (clock),
    .clearn (clearn),
    .clr    (buf_clr),
    .shift  (shift),
    .din    (bus.key_code),
    .digits (bus.digits_out),
    .count  (count),
    .full   (full)
  );

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state       <= ST_IDLE;
      key_valid_q <= 1'b0;
      load_cnt    <= '0;
      loadn_r     <= 1'b1;
      load_done_r <= 1'b0;
    end else begin
      key_valid_q <= bus.key_valid;
      load_done_r <= 1'b0;
      case (state)
        ST_IDLE, ST_ENTRY: begin
          if (bus.key_clear) begin
            state <= ST_IDLE;
          end else if (start_ok) begin
            state    <= ST_LOAD;
            loadn_r  <= 1'b0;
            load_cnt <= 4'(LOAD_CYCLES);
          end else if (shift) begin
            state <= ST_ENTRY;
          end
        end
        ST_LOAD: begin
          // Counters started underneath us: abandon the load but keep what was typed.
          if (bus.timer_running) begin
            loadn_r <= 1'b1;
            state   <= ST_ENTRY;
          end else if (load_cnt == 4'd1) begin
            loadn_r     <= 1'b1;
            load_done_r <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            load_cnt <= load_cnt - 4'd1;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.loadn       = loadn_r;
  assign bus.load_done   = load_done_r;
  assign bus.digit_count = count;

endmodule
